// File: rtl/mesh_boot_ctrl.sv
// mesh_boot_ctrl: sequenced boot engine streaming images into mesh tiles (MESH_BOOT_BROADCAST_EN enables broadcast at processor_select == NUM_PROC)
module mesh_boot_ctrl #(
  parameter int NUM_PROC = 6,
  parameter int PSEL_W   = 4,
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 32,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [PSEL_W-1:0]   processor_select,
  input  logic                boot_start,
  input  logic                boot_abort,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic                s_kind,
  input  logic [ADDR_W-1:0]   s_addr,
  input  logic [DATA_W-1:0]   s_data,
  input  logic                s_last,
  output logic [ADDR_W-1:0]   boot_iaddr,
  output logic [DATA_W-1:0]   boot_idata,
  output logic [ADDR_W-1:0]   boot_daddr,
  output logic [DATA_W-1:0]   boot_ddata,
  output logic [NUM_PROC-1:0] boot_iwe,
  output logic [NUM_PROC-1:0] boot_dwe,
  output logic [NUM_PROC-1:0] proc_resetn,
  output logic [NUM_PROC-1:0] booted,
  output logic                busy,
  output logic                err,
  output logic [CNT_W-1:0]    beat_count
);
  typedef enum logic [1:0] {IDLE, LOAD, RELEASE} state_t;
  state_t              state_q, state_d;
  logic [NUM_PROC-1:0] mask_q, mask_d, iwe_q, iwe_d, dwe_q, dwe_d;
  logic [NUM_PROC-1:0] prst_q, prst_d, booted_q, booted_d;
  logic [ADDR_W-1:0]   iaddr_q, iaddr_d, daddr_q, daddr_d;
  logic [DATA_W-1:0]   idata_q, idata_d, ddata_q, ddata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                sel_ok;
  logic [NUM_PROC-1:0] sel_mask;
  // the selected tile is carried as a one-hot (or all-ones) mask so broadcast needs no extra path
`ifdef MESH_BOOT_BROADCAST_EN
  assign sel_ok   = 32'(processor_select) <= NUM_PROC;
  assign sel_mask = (32'(processor_select) == NUM_PROC) ? '1 : NUM_PROC'(1) << processor_select;
`else
  assign sel_ok   = 32'(processor_select) < NUM_PROC;
  assign sel_mask = NUM_PROC'(1) << processor_select;
`endif
  assign s_ready     = state_q == LOAD;
  assign busy        = state_q != IDLE;
  assign err         = err_q;
  assign beat_count  = cnt_q;
  assign boot_iaddr  = iaddr_q;
  assign boot_idata  = idata_q;
  assign boot_daddr  = daddr_q;
  assign boot_ddata  = ddata_q;
  assign boot_iwe    = iwe_q;
  assign boot_dwe    = dwe_q;
  assign proc_resetn = prst_q;
  assign booted      = booted_q;
  // next-state: strobes default low so each accepted beat pulses exactly one cycle
  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    iwe_d    = '0;
    dwe_d    = '0;
    prst_d   = prst_q;
    booted_d = booted_q;
    iaddr_d  = iaddr_q;
    idata_d  = idata_q;
    daddr_d  = daddr_q;
    ddata_d  = ddata_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    case (state_q)
      IDLE: if (boot_start) begin
        if (sel_ok) begin
          mask_d   = sel_mask;
          prst_d   = prst_q & ~sel_mask;
          booted_d = booted_q & ~sel_mask;
          err_d    = 1'b0;
          cnt_d    = '0;
          state_d  = LOAD;
        end else err_d = 1'b1;
      end
      LOAD: if (boot_abort) begin
        err_d   = 1'b1;
        state_d = IDLE;
      end else if (s_valid) begin
        if (s_kind) begin
          daddr_d = s_addr;
          ddata_d = s_data;
          dwe_d   = mask_q;
        end else begin
          iaddr_d = s_addr;
          idata_d = s_data;
          iwe_d   = mask_q;
        end
        cnt_d   = &cnt_q ? cnt_q : cnt_q + 1'b1;
        state_d = s_last ? RELEASE : LOAD;
      end
      RELEASE: begin
        err_d    = err_q | boot_abort;
        prst_d   = boot_abort ? prst_q : prst_q | mask_q;
        booted_d = boot_abort ? booted_q : booted_q | mask_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state register; asynchronous reset holds every tile in reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      mask_q   <= '0;
      iwe_q    <= '0;
      dwe_q    <= '0;
      prst_q   <= '0;
      booted_q <= '0;
      iaddr_q  <= '0;
      idata_q  <= '0;
      daddr_q  <= '0;
      ddata_q  <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      iwe_q    <= iwe_d;
      dwe_q    <= dwe_d;
      prst_q   <= prst_d;
      booted_q <= booted_d;
      iaddr_q  <= iaddr_d;
      idata_q  <= idata_d;
      daddr_q  <= daddr_d;
      ddata_q  <= ddata_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end
endmodule
